// File: rtl/acia_6502.sv
// 6502-bus UART responder: 8N1 transmitter with one holding register, receiver with
// a small RX FIFO, four byte registers, registered read data and a level irq.
module acia_6502 #(
  parameter int DIV          = 40,
  parameter int RXDEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq,
  input  logic       rx,
  output logic       tx
);

  localparam int CW    = $clog2(DIV);
  localparam int DEPTH = 1 << RXDEPTH_LOG2;

  localparam logic [CW-1:0]         BIT_END  = CW'(DIV - 1);
  localparam logic [CW-1:0]         HALF_END = CW'(DIV / 2 - 1);
  localparam logic [RXDEPTH_LOG2:0] FULL     = (RXDEPTH_LOG2 + 1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Transmit side
  logic [7:0]    tx_hold, tx_shift;
  logic          tx_full;
  logic [1:0]    tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;

  // Receive side
  logic          rx_s1, rx_s2, rx_s3;
  logic [1:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;

  // FIFO and register state
  logic [7:0]              fifo_mem [DEPTH];
  logic [RXDEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [RXDEPTH_LOG2:0]   rx_count;
  logic                    ovr, fe;
  logic [1:0]              ctrl;

  logic bus_wr, bus_rd, pop, rx_push, push_ok, rx_ne, tx_busy;
  logic [7:0] status;

  assign bus_wr  = cs & we;
  assign bus_rd  = cs & ~we;
  assign rx_ne   = (rx_count != '0);
  assign pop     = bus_rd && (addr == 2'd0) && rx_ne;
  assign rx_push = (rx_state == S_STOP) && (rx_cnt == BIT_END);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign push_ok = rx_push && ((rx_count != FULL) || pop);
  assign tx_busy = (tx_state != S_IDLE);
  assign status  = {irq, 2'b00, tx_busy, fe, ovr, ~tx_full, rx_ne};

  // NOTE: every sequential block uses non-blocking assignments so that all state
  // updates see the pre-edge values of their inputs, independent of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_hold  <= '0;
      tx_shift <= '0;
      tx_full  <= 1'b0;
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx       <= 1'b1;
    end else begin
      if (bus_wr && (addr == 2'd0) && !tx_full) begin
        tx_hold <= din;
        tx_full <= 1'b1;
      end
      tx_cnt <= (tx_state == S_IDLE || tx_cnt == BIT_END) ? '0 : tx_cnt + CW'(1);
      case (tx_state)
        S_IDLE: if (tx_full) begin
          tx_shift <= tx_hold;
          tx_full  <= 1'b0;
          tx_state <= S_START;
          tx       <= 1'b0;
        end
        S_START: if (tx_cnt == BIT_END) begin
          tx_state <= S_DATA;
          tx_bit   <= '0;
          tx       <= tx_shift[0];
        end
        S_DATA: if (tx_cnt == BIT_END) begin
          if (tx_bit == 3'd7) begin
            tx_state <= S_STOP;
            tx       <= 1'b1;
          end else begin
            tx_bit   <= tx_bit + 3'd1;
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx       <= tx_shift[1];
          end
        end
        default: if (tx_cnt == BIT_END) begin
          // Back-to-back frames: reload straight into START with no idle bit.
          if (tx_full) begin
            tx_shift <= tx_hold;
            tx_full  <= 1'b0;
            tx_state <= S_START;
            tx       <= 1'b0;
          end else begin
            tx_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      case (rx_state)
        S_IDLE: begin
          rx_cnt <= '0;
          if (rx_s3 && !rx_s2) rx_state <= S_START;
        end
        S_START: if (rx_cnt == HALF_END) begin
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_state <= rx_s2 ? S_IDLE : S_DATA;
        end else begin
          rx_cnt <= rx_cnt + CW'(1);
        end
        S_DATA: if (rx_cnt == BIT_END) begin
          rx_cnt   <= '0;
          rx_shift <= {rx_s2, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state <= S_STOP;
          else                rx_bit   <= rx_bit + 3'd1;
        end else begin
          rx_cnt <= rx_cnt + CW'(1);
        end
        default: if (rx_cnt == BIT_END) begin
          rx_cnt   <= '0;
          rx_state <= S_IDLE;
        end else begin
          rx_cnt <= rx_cnt + CW'(1);
        end
      endcase
    end
  end

  // NOTE: the FIFO storage has no reset; the pointers and count define which
  // entries are valid, and leaving the array unreset keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= rx_shift;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_count <= '0;
      ovr      <= 1'b0;
      fe       <= 1'b0;
      ctrl     <= 2'b00;
      dout     <= 8'h00;
      irq      <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase

      if (bus_wr && (addr == 2'd3)) begin
        ovr <= 1'b0;
        fe  <= 1'b0;
      end
      if (rx_push && !push_ok) ovr <= 1'b1;
      if (rx_push && !rx_s2)   fe  <= 1'b1;
      if (bus_wr && (addr == 2'd2)) ctrl <= din[1:0];

      if (bus_rd) begin
        case (addr)
          2'd0:    dout <= pop ? fifo_mem[rd_ptr] : 8'h00;
          2'd1:    dout <= status;
          2'd2:    dout <= {6'b0, ctrl};
          default: dout <= 8'h00;
        endcase
      end

      irq <= (ctrl[0] & rx_ne) | (ctrl[1] & ~tx_full);
    end
  end

endmodule
